// File: rtl/delta_fifo_ctrl_pkg.sv
// delta_fifo_ctrl_pkg
//   Shared definitions for the delta-word FIFO path: default RAM geometry
//   for the delta SRAM and the output-buffer occupancy encoding.
package delta_fifo_ctrl_pkg;

    localparam int DELTA_DEPTH_BIT = 6;
    localparam int DELTA_WIDTH     = 28;

    // Output buffer occupancy, 0..2 words.
    typedef logic [1:0] occ_t;
    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_TWO   = 2'd2;

    // Words already committed to the output side: buffered plus in flight.
    function automatic logic [1:0] pending(input occ_t occ, input logic inflight);
        return occ + {1'b0, inflight};
    endfunction

endpackage

// File: rtl/delta_fifo_ctrl_if.sv
// delta_fifo_ctrl_if
//   Stream handshake bundle for the delta FIFO.
//   in_valid/in_ready/in_data   : upstream producer -> controller
//   out_valid/out_ready/out_data: controller -> downstream consumer
//   slave  : the controller side
//   master : the environment side (producer + consumer)
interface delta_fifo_ctrl_if
    import delta_fifo_ctrl_pkg::*;
#(
    parameter int SRAM_WIDTH = DELTA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SRAM_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SRAM_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/delta_fifo_ctrl_out_buf.sv
// delta_out_buf
//   2-entry register FIFO that holds words returned from the RAM.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous flush (drops everything, including a capture)
//   cap        : write cap_data this cycle
//   pop        : drop the head this cycle (caller only pops when occ != 0)
//   occ        : occupancy 0..2
//   head       : registered head word
module delta_out_buf
    import delta_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = DELTA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cap,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= OCC_EMPTY;
            head <= '0;
            tail <= '0;
        end else if (clr) begin
            occ <= OCC_EMPTY;
        end else begin
            unique case ({cap, pop})
                2'b10: begin
                    if (occ == OCC_EMPTY) head <= cap_data;
                    else                  tail <= cap_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (occ == OCC_TWO) begin
                        head <= tail;
                        tail <= cap_data;
                    end else begin
                        head <= cap_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/delta_fifo_ctrl.sv
// delta_fifo_ctrl
//   Valid/ready stream FIFO built on a single-port delta SRAM (1-cycle read
//   latency). At most one RAM access per cycle; a 2-entry output buffer hides
//   the read latency.
//   clk, rst_n          : clock, async active-low reset
//   clr                 : synchronous flush
//   io (slave)          : in_* / out_* stream handshakes
//   ram_addr_w/_r       : write / read pointers
//   ram_write_en/_read_en: never both high
//   ram_data_in         : write data (= in_data)
//   ram_data_out        : read data, valid the cycle after ram_read_en
//   count               : words held (RAM + in flight + output buffer)
module delta_fifo_ctrl
    import delta_fifo_ctrl_pkg::*;
#(
    parameter int SRAM_DEPTH_BIT = DELTA_DEPTH_BIT,
    parameter int SRAM_DEPTH     = 2**SRAM_DEPTH_BIT,
    parameter int SRAM_WIDTH     = DELTA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    delta_fifo_ctrl_if.slave          io,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_w,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
    output logic                      ram_write_en,
    output logic                      ram_read_en,
    output logic [SRAM_WIDTH-1:0]     ram_data_in,
    input  logic [SRAM_WIDTH-1:0]     ram_data_out,
    output logic [SRAM_DEPTH_BIT+1:0] count
);

    localparam logic [SRAM_DEPTH_BIT:0] FULL_CNT = (SRAM_DEPTH_BIT+1)'(SRAM_DEPTH);

    logic [SRAM_DEPTH_BIT-1:0] wptr, rptr;
    logic [SRAM_DEPTH_BIT:0]   ram_cnt;
    logic                      inflight;
    occ_t                      occ;
    logic [1:0]                pend;
    logic                      ram_nonempty, urgent, in_ready, wr_en, rd_en, pop;
    logic [SRAM_WIDTH-1:0]     head;

    assign pend         = pending(occ, inflight);
    assign ram_nonempty = (ram_cnt != '0);
    // Output side has nothing coming while the RAM holds data: the read must
    // win over a write this cycle or the stream stalls.
    assign urgent       = ram_nonempty && (pend == 2'd0);
    assign in_ready     = rst_n && !clr && (ram_cnt != FULL_CNT) && !urgent;
    assign wr_en        = io.in_valid && in_ready;
    assign rd_en        = !clr && (urgent || (ram_nonempty && (pend < 2'd2) && !wr_en));
    assign pop          = io.out_valid && io.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            ram_cnt  <= ram_cnt + {{SRAM_DEPTH_BIT{1'b0}}, wr_en}
                                - {{SRAM_DEPTH_BIT{1'b0}}, rd_en};
            inflight <= rd_en;
        end
    end

    // clr inside the buffer also discards a capture of in-flight read data.
    delta_out_buf #(.WIDTH(SRAM_WIDTH)) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .cap      (inflight),
        .cap_data (ram_data_out),
        .pop      (pop),
        .occ      (occ),
        .head     (head)
    );

    assign io.in_ready   = in_ready;
    assign io.out_valid  = (occ != OCC_EMPTY);
    assign io.out_data   = head;
    assign ram_addr_w    = wptr;
    assign ram_addr_r    = rptr;
    assign ram_write_en  = wr_en;
    assign ram_read_en   = rd_en;
    assign ram_data_in   = io.in_data;
    assign count         = (SRAM_DEPTH_BIT+2)'(ram_cnt) + (SRAM_DEPTH_BIT+2)'(inflight)
                         + (SRAM_DEPTH_BIT+2)'(occ);

endmodule

// File: tb/tb_delta_fifo_ctrl.sv
// tb_delta_fifo_ctrl
//   Bench for delta_fifo_ctrl with a behavioural single-port RAM and a queue
//   reference model of the stream contents.
module tb_delta_fifo_ctrl;
    import delta_fifo_ctrl_pkg::*;

    localparam int DB    = 6;
    localparam int DEPTH = 64;
    localparam int W     = 28;
    localparam int CW    = DB + 2;

    logic clk = 1'b0;
    logic rst_n, clr;
    always #5 clk = ~clk;

    delta_fifo_ctrl_if #(.SRAM_WIDTH(W)) dif ();

    logic [DB-1:0] aw, ar;
    logic          we, re;
    logic [W-1:0]  din, rdo;
    logic [CW-1:0] count;

    delta_fifo_ctrl #(.SRAM_DEPTH_BIT(DB), .SRAM_DEPTH(DEPTH), .SRAM_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .io           (dif.slave),
        .ram_addr_w   (aw),
        .ram_addr_r   (ar),
        .ram_write_en (we),
        .ram_read_en  (re),
        .ram_data_in  (din),
        .ram_data_out (rdo),
        .count        (count)
    );

    // Single-port RAM model: 1-cycle read latency.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (we) mem[aw] <= din;
        if (re) rdo <= mem[ar];
    end

    int checks = 0;
    int failures = 0;
    int both_en_seen = 0;
    logic [W-1:0] q[$];

    always @(posedge clk) if (we && re) both_en_seen++;

    // One clock of stimulus, entered and left just after a falling edge.
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy,
                         output logic acc, output logic popped, output logic [W-1:0] pdata,
                         output logic re_s, output logic rdy_s);
        dif.in_valid  = iv;
        dif.in_data   = d;
        dif.out_ready = ordy;
        #1;
        acc    = dif.in_valid && dif.in_ready;
        popped = dif.out_valid && dif.out_ready;
        pdata  = dif.out_data;
        re_s   = re;
        rdy_s  = dif.in_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        dif.in_valid  = 1'b0;
        dif.in_data   = '0;
        dif.out_ready = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        dif.in_valid  = 1'b1;
        dif.in_data   = 28'h1234567;
        dif.out_ready = 1'b1;
        clr   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++; if (dif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", dif.out_valid); end
        checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (dif.out_data !== '0) begin failures++; $display("FAIL reset_out_data got %h want 0", dif.out_data); end
        checks++; if (dif.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b want 0", dif.in_ready); end
        checks++; if ({we, re} !== 2'b00) begin failures++; $display("FAIL reset_ram_en got %b want 00", {we, re}); end
        dif.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; #1;
        checks++; if (dif.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got %b want 1", dif.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_first_word();
        do_reset();
        dif.in_valid = 1'b1; dif.in_data = 28'h0ABCDEF; dif.out_ready = 1'b1; #1;
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL first_write_E0 got %b want 1", we); end
        @(posedge clk); @(negedge clk);
        dif.in_valid = 1'b0; #1;
        checks++; if ({we, re} !== 2'b01) begin failures++; $display("FAIL first_read_E1 got we,re=%b want 01", {we, re}); end
        @(posedge clk); @(negedge clk); #1;
        checks++; if (dif.out_valid !== 1'b0) begin failures++; $display("FAIL first_early_valid got %b want 0", dif.out_valid); end
        @(posedge clk); @(negedge clk); #1;
        checks++; if (dif.out_valid !== 1'b1 || dif.out_data !== 28'h0ABCDEF)
            begin failures++; $display("FAIL first_out got v=%b d=%h want v=1 d=0abcdef", dif.out_valid, dif.out_data); end
        checks++; if (count !== CW'(1)) begin failures++; $display("FAIL first_count got %0d want 1", count); end
        @(posedge clk); @(negedge clk); #1;
        checks++; if (count !== '0 || dif.out_valid !== 1'b0)
            begin failures++; $display("FAIL first_after_pop got count=%0d v=%b want 0 0", count, dif.out_valid); end
        dif.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        logic acc, popped, re_s, rdy_s;
        logic [W-1:0] pdata, exp;
        int pushed, first_re, popcnt;
        do_reset();
        pushed = 0;
        for (int c = 0; c < 400 && pushed < DEPTH + 2; c++) begin
            cycle(1'b1, W'(pushed), 1'b0, acc, popped, pdata, re_s, rdy_s);
            if (acc) begin q.push_back(W'(pushed)); pushed++; end
        end
        checks++; if (pushed != DEPTH + 2) begin failures++; $display("FAIL fill_timeout got %0d pushes want %0d", pushed, DEPTH + 2); end
        checks++; if (count !== CW'(DEPTH + 2)) begin failures++; $display("FAIL fill_count got %0d want %0d", count, DEPTH + 2); end
        cycle(1'b1, W'(DEPTH + 2), 1'b0, acc, popped, pdata, re_s, rdy_s);
        checks++; if (rdy_s !== 1'b0 || acc !== 1'b0) begin failures++; $display("FAIL full_stall got in_ready=%b want 0", rdy_s); end
        checks++; if (count !== CW'(DEPTH + 2)) begin failures++; $display("FAIL full_hold_count got %0d want %0d", count, DEPTH + 2); end

        first_re = -1;
        popcnt = 0;
        for (int c = 0; c < 400 && q.size() > 0; c++) begin
            cycle(1'b0, '0, 1'b1, acc, popped, pdata, re_s, rdy_s);
            if (first_re >= 0 && c == first_re + 1) begin
                checks++; if (rdy_s !== 1'b1) begin failures++; $display("FAIL drain_ready_reassert got %b want 1", rdy_s); end
            end
            if (re_s && first_re < 0) begin
                first_re = c;
                checks++; if (rdy_s !== 1'b0) begin failures++; $display("FAIL drain_ready_early got %b want 0", rdy_s); end
            end
            if (popped) begin
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL drain_extra got %h want none", pdata); end
                else begin
                    exp = q.pop_front(); popcnt++;
                    if (pdata !== exp) begin failures++; $display("FAIL drain_order got %h want %h", pdata, exp); end
                end
            end
        end
        checks++; if (popcnt != DEPTH + 2 || count !== '0)
            begin failures++; $display("FAIL drain_done got pops=%0d count=%0d want %0d 0", popcnt, count, DEPTH + 2); end
    endtask

    task automatic test_random();
        logic acc, popped, re_s, rdy_s, iv, ordy;
        logic [W-1:0] pdata, exp, d;
        int ph;
        do_reset();
        both_en_seen = 0;
        for (int c = 0; c < 10000; c++) begin
            ph   = (c / 500) % 4;
            iv   = ($urandom_range(0, 3) >= ph);
            ordy = ($urandom_range(0, 3) <= ph);
            d    = W'($urandom);
            cycle(iv, d, ordy, acc, popped, pdata, re_s, rdy_s);
            if (popped) begin
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL rand_extra cyc %0d got %h want none", c, pdata); end
                else begin
                    exp = q.pop_front();
                    if (pdata !== exp) begin failures++; $display("FAIL rand_order cyc %0d got %h want %h", c, pdata, exp); end
                end
            end
            if (acc) q.push_back(d);
            checks++;
            if (count !== CW'(q.size())) begin failures++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, count, q.size()); end
        end
        checks++; if (both_en_seen != 0) begin failures++; $display("FAIL rand_both_en got %0d want 0", both_en_seen); end
    endtask

    task automatic test_clr();
        logic acc, popped, re_s, rdy_s;
        logic [W-1:0] pdata;
        int pushed, seen;
        do_reset();
        pushed = 0;
        for (int c = 0; c < 50 && pushed < 5; c++) begin
            cycle(1'b1, W'(28'h0A00000 + pushed), 1'b0, acc, popped, pdata, re_s, rdy_s);
            if (acc) pushed++;
        end
        cycle(1'b0, '0, 1'b0, acc, popped, pdata, re_s, rdy_s);
        checks++; if (re_s !== 1'b1) begin failures++; $display("FAIL clr_prefetch got re=%b want 1", re_s); end
        checks++; if (count !== CW'(5)) begin failures++; $display("FAIL clr_pre_count got %0d want 5", count); end
        clr = 1'b1; dif.in_valid = 1'b1; dif.in_data = 28'h0BADBAD; #1;
        checks++; if (dif.in_ready !== 1'b0 || {we, re} !== 2'b00)
            begin failures++; $display("FAIL clr_block got rdy=%b we,re=%b want 0 00", dif.in_ready, {we, re}); end
        @(posedge clk); @(negedge clk);
        clr = 1'b0; dif.in_valid = 1'b0; #1;
        checks++; if (count !== '0 || dif.out_valid !== 1'b0)
            begin failures++; $display("FAIL clr_flush got count=%0d v=%b want 0 0", count, dif.out_valid); end
        @(posedge clk); @(negedge clk); #1;
        checks++; if (count !== '0 || dif.out_valid !== 1'b0)
            begin failures++; $display("FAIL clr_discard got count=%0d v=%b want 0 0", count, dif.out_valid); end
        @(negedge clk);
        cycle(1'b1, 28'h1234567, 1'b0, acc, popped, pdata, re_s, rdy_s);
        dif.in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            #1; if (dif.out_valid) seen = 1; else @(negedge clk);
        end
        checks++; if (seen == 0 || dif.out_data !== 28'h1234567)
            begin failures++; $display("FAIL clr_next_word got v=%0d d=%h want 1 1234567", seen, dif.out_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        logic acc, popped, re_s, rdy_s;
        logic [W-1:0] pdata;
        int pushed;
        do_reset();
        pushed = 0;
        for (int c = 0; c < 60 && pushed < 10; c++) begin
            cycle(1'b1, W'(28'h0000100 + pushed), 1'b0, acc, popped, pdata, re_s, rdy_s);
            if (acc) pushed++;
        end
        dif.in_valid = 1'b0; #1;
        checks++; if (count !== CW'(10) || dif.out_data !== 28'h0000100)
            begin failures++; $display("FAIL mid_pre got count=%0d d=%h want 10 0000100", count, dif.out_data); end
        rst_n = 1'b0; #1;
        checks++; if (dif.out_valid !== 1'b0 || count !== '0 || dif.out_data !== '0 || dif.in_ready !== 1'b0)
            begin failures++; $display("FAIL mid_async got v=%b count=%0d d=%h rdy=%b want 0 0 0 0",
                                       dif.out_valid, count, dif.out_data, dif.in_ready); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        checks++; if (dif.in_ready !== 1'b1 || count !== '0)
            begin failures++; $display("FAIL mid_release got rdy=%b count=%0d want 1 0", dif.in_ready, count); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_fill_drain();
        test_random();
        test_clr();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
